// File: rtl/aes_pkg.sv
// Shared types and index helpers for the byte-serial AES SubBytes/ShiftRows stage.
package aes_pkg;

    localparam int AES_BLOCK_BYTES = 16;

    typedef enum logic {
        LOAD  = 1'b0,
        DRAIN = 1'b1
    } fsm_t;

    // Output slot cnt (row r, column c) reads the byte that ShiftRows moves there: row r, column (c + r) mod 4.
    function automatic logic [3:0] shift_rows_idx(input logic [3:0] cnt);
        logic [1:0] row;
        logic [1:0] col;
        row = cnt[1:0];
        col = cnt[3:2] + row;
        return {col, row};
    endfunction

endpackage

// File: rtl/AES_SBox_LUT.sv
// Combinational AES forward S-box as a 256-entry constant table.
module AES_SBox_LUT (
    input  logic [7:0] in,
    output logic [7:0] out
);

    localparam logic [7:0] SBOX_TABLE [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    assign out = SBOX_TABLE[in];

endmodule

// File: rtl/aes_subshift_serial.sv
// Byte-serial AES SubBytes + ShiftRows: loads 16 substituted bytes, then drains them in round order.
module aes_subshift_serial
    import aes_pkg::*;
#(
    parameter bit SHIFT_ROWS = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       flush,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic       out_last,
    output logic       busy
);

    localparam logic [3:0] LAST_IDX = 4'(AES_BLOCK_BYTES - 1);

    fsm_t       r_state;
    logic [3:0] r_cnt;
    logic [7:0] r_buf [AES_BLOCK_BYTES];

    logic       w_in_fire;
    logic       w_out_fire;
    logic [7:0] w_sbox;
    logic [3:0] w_rd_idx;

    AES_SBox_LUT u_sbox (
        .in  (in_data),
        .out (w_sbox)
    );

    assign in_ready   = (r_state == LOAD);
    assign out_valid  = (r_state == DRAIN);
    assign out_last   = out_valid && (r_cnt == LAST_IDX);
    assign busy       = (r_state != LOAD) || (r_cnt != 4'd0);
    assign w_in_fire  = in_valid && in_ready;
    assign w_out_fire = out_valid && out_ready;
    assign w_rd_idx   = SHIFT_ROWS ? shift_rows_idx(r_cnt) : r_cnt;
    assign out_data   = out_valid ? r_buf[w_rd_idx] : 8'h00;

    // Flush outranks any same-cycle transfer; cnt wraps naturally at 16.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= LOAD;
            r_cnt   <= 4'd0;
        end else if (flush) begin
            r_state <= LOAD;
            r_cnt   <= 4'd0;
        end else if (r_state == LOAD) begin
            if (w_in_fire) begin
                r_cnt <= r_cnt + 4'd1;
                if (r_cnt == LAST_IDX) r_state <= DRAIN;
            end
        end else begin
            if (w_out_fire) begin
                r_cnt <= r_cnt + 4'd1;
                if (r_cnt == LAST_IDX) r_state <= LOAD;
            end
        end
    end

    // NOTE: the data buffer has no reset; every slot is rewritten before it is read, so resetting it only costs logic.
    always_ff @(posedge clk) begin
        if (w_in_fire && !flush) r_buf[r_cnt] <= w_sbox;
    end

endmodule

// File: tb/tb_aes_subshift_serial.sv
// Scoreboard bench: two instances (ShiftRows on/off) share stimulus; a monitor checks every output transfer.
module tb_aes_subshift_serial;

    typedef logic [7:0] blk_t [16];
    typedef struct {
        logic [7:0] data;
        logic       last;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       flush = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       out_ready = 1'b0;

    logic       in_ready  [2];
    logic       out_valid [2];
    logic [7:0] out_data  [2];
    logic       out_last  [2];
    logic       busy      [2];

    aes_subshift_serial #(.SHIFT_ROWS(1'b1)) dut_sr (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready[0]), .in_data(in_data),
        .out_valid(out_valid[0]), .out_ready(out_ready), .out_data(out_data[0]),
        .out_last(out_last[0]), .busy(busy[0])
    );

    aes_subshift_serial #(.SHIFT_ROWS(1'b0)) dut_ld (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready[1]), .in_data(in_data),
        .out_valid(out_valid[1]), .out_ready(out_ready), .out_data(out_data[1]),
        .out_last(out_last[1]), .busy(busy[1])
    );

    always #5 clk = ~clk;

    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   last_cyc = -100;
    int   ready_mode = 2;  // 0: always ready, 1: random, 2: hold low, 3: driven by the test
    exp_t q_sr [$];
    exp_t q_ld [$];
    logic       stall  [2] = '{1'b0, 1'b0};
    logic [7:0] st_dat [2];
    logic       st_lst [2];

    blk_t v1_in  = '{8'h19, 8'h3d, 8'he3, 8'hbe, 8'ha0, 8'hf4, 8'he2, 8'h2b,
                     8'h9a, 8'hc6, 8'h8d, 8'h2a, 8'he9, 8'hf8, 8'h48, 8'h08};
    blk_t v1_sr  = '{8'hd4, 8'hbf, 8'h5d, 8'h30, 8'he0, 8'hb4, 8'h52, 8'hae,
                     8'hb8, 8'h41, 8'h11, 8'hf1, 8'h1e, 8'h27, 8'h98, 8'he5};
    blk_t v1_ld  = '{8'hd4, 8'h27, 8'h11, 8'hae, 8'he0, 8'hbf, 8'h98, 8'hf1,
                     8'hb8, 8'hb4, 8'h5d, 8'he5, 8'h1e, 8'h41, 8'h52, 8'h30};
    blk_t z_in   = '{default: 8'h00};
    blk_t z_out  = '{default: 8'h63};
    blk_t f_in   = '{default: 8'h53};
    blk_t f_out  = '{default: 8'hed};
    blk_t part_in = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h00,
                      8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_block(input blk_t e_sr, input blk_t e_ld);
        for (int i = 0; i < 16; i++) begin
            q_sr.push_back('{data: e_sr[i], last: (i == 15)});
            q_ld.push_back('{data: e_ld[i], last: (i == 15)});
        end
    endtask

    // Drives one byte and returns at posedge+1 after it was accepted; acc is the negedge cycle of acceptance.
    task automatic send_byte(input logic [7:0] b, output int acc);
        int t = 0;
        in_valid = 1'b1;
        in_data  = b;
        @(negedge clk);
        while (!in_ready[0] && t < 200) begin
            t++;
            @(negedge clk);
        end
        if (t >= 200) check("in_ready timeout", 32'(in_ready[0]), 32'd1);
        acc = cyc;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_n(input blk_t d, input int n, output int first_acc);
        int acc;
        first_acc = -1;
        for (int i = 0; i < n; i++) begin
            send_byte(d[i], acc);
            if (i == 0) first_acc = acc;
        end
    endtask

    task automatic wait_drain();
        int t = 0;
        while ((q_sr.size() != 0 || q_ld.size() != 0) && t < 500) begin
            t++;
            @(negedge clk);
        end
        check("drain timeout", 32'(q_sr.size() + q_ld.size()), 32'd0);
    endtask

    task automatic mon(input int id);
        exp_t  e;
        string tag;
        tag = (id == 0) ? "sr" : "ld";
        if (rst) begin
            stall[id] = 1'b0;
            return;
        end
        if (out_valid[id]) check({tag, " in_ready in drain"}, 32'(in_ready[id]), 32'd0);
        if (stall[id] && out_valid[id]) begin
            check({tag, " stall data hold"}, 32'(out_data[id]), 32'(st_dat[id]));
            check({tag, " stall last hold"}, 32'(out_last[id]), 32'(st_lst[id]));
        end
        if (out_valid[id] && out_ready && !flush) begin
            if ((id == 0 && q_sr.size() == 0) || (id == 1 && q_ld.size() == 0)) begin
                check({tag, " unexpected output"}, 32'(out_data[id]), 32'hffff_ffff);
            end else begin
                e = (id == 0) ? q_sr.pop_front() : q_ld.pop_front();
                check({tag, " data"}, 32'(out_data[id]), 32'(e.data));
                check({tag, " last"}, 32'(out_last[id]), 32'(e.last));
                if (id == 0 && out_last[id]) last_cyc = cyc;
            end
        end
        stall[id]  = out_valid[id] && !out_ready && !flush;
        st_dat[id] = out_data[id];
        st_lst[id] = out_last[id];
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(posedge clk);
        #1;
        case (ready_mode)
            0: out_ready = 1'b1;
            1: out_ready = ($urandom_range(0, 3) != 0);
            2: out_ready = 1'b0;
            default: ;
        endcase
    end

    initial forever begin
        @(negedge clk);
        mon(0);
        mon(1);
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int first2;

        // Reset values
        #12;
        for (int i = 0; i < 2; i++) begin
            check("reset out_valid", 32'(out_valid[i]), 32'd0);
            check("reset in_ready", 32'(in_ready[i]), 32'd1);
            check("reset busy", 32'(busy[i]), 32'd0);
            check("reset out_last", 32'(out_last[i]), 32'd0);
            check("reset out_data", 32'(out_data[i]), 32'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Vector 1, no stalls; first output valid right after the 16th accept
        ready_mode = 0;
        push_block(v1_sr, v1_ld);
        send_n(v1_in, 16, acc);
        check("latency out_valid", 32'(out_valid[0]), 32'd1);
        wait_drain();

        // Zeros then 0x53 back to back; next block accepted the cycle after out_last
        push_block(z_out, z_out);
        push_block(f_out, f_out);
        send_n(z_in, 16, acc);
        send_n(f_in, 16, first2);
        check("next block accept cycle", 32'(first2), 32'(last_cyc + 1));
        wait_drain();

        // Random output stalls on vector 1
        ready_mode = 1;
        push_block(v1_sr, v1_ld);
        send_n(v1_in, 16, acc);
        wait_drain();

        // Flush after 7 bytes, colliding with an 8th input byte
        ready_mode = 0;
        send_n(part_in, 7, acc);
        check("partial busy", 32'(busy[0]), 32'd1);
        in_valid = 1'b1;
        in_data  = 8'haa;
        flush    = 1'b1;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush load busy", 32'(busy[0]), 32'd0);
        check("flush load busy ld", 32'(busy[1]), 32'd0);
        push_block(v1_sr, v1_ld);
        send_n(v1_in, 16, acc);
        wait_drain();

        // Flush together with the output transfer at cnt = 5
        ready_mode = 2;
        push_block(v1_sr, v1_ld);
        send_n(v1_in, 16, acc);
        ready_mode = 3;
        out_ready  = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush     = 1'b0;
        out_ready = 1'b0;
        check("flush drain out_valid", 32'(out_valid[0]), 32'd0);
        check("flush drain in_ready", 32'(in_ready[0]), 32'd1);
        check("flush drain busy", 32'(busy[1]), 32'd0);
        check("flush drain remaining", 32'(q_sr.size()), 32'd11);
        q_sr.delete();
        q_ld.delete();

        // Asynchronous reset at cnt = 15 in DRAIN
        push_block(v1_sr, v1_ld);
        send_n(v1_in, 16, acc);
        out_ready = 1'b1;
        repeat (15) @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("pre-reset out_last", 32'(out_last[0]), 32'd1);
        check("pre-reset out_last ld", 32'(out_last[1]), 32'd1);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        for (int i = 0; i < 2; i++) begin
            check("async rst out_valid", 32'(out_valid[i]), 32'd0);
            check("async rst out_last", 32'(out_last[i]), 32'd0);
            check("async rst busy", 32'(busy[i]), 32'd0);
            check("async rst in_ready", 32'(in_ready[i]), 32'd1);
        end
        check("rst remaining", 32'(q_sr.size()), 32'd1);
        q_sr.delete();
        q_ld.delete();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("post-rst out_valid", 32'(out_valid[0]), 32'd0);
        end
        @(posedge clk);
        #1;
        ready_mode = 0;
        push_block(v1_sr, v1_ld);
        send_n(v1_in, 16, acc);
        wait_drain();

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/aes_subshift_serial.md
Name: aes_subshift_serial

Overview:
- Byte-serial AES round front end.
- Accepts a 16-byte AES state one byte per cycle and substitutes each byte on capture through one combinational AES S-box instance.
- Buffers the substituted state, then streams it out byte-serially in ShiftRows order.
- Sits between the 8-bit pin-level input path and the downstream MixColumns/AddRoundKey stage. It is the stage that consumes S-box results and assembles them into round state.

Parameters:
- SHIFT_ROWS, 1, 1 = output in ShiftRows order; 0 = output in load order (SubBytes only).

Ports:
- clk, input, 1, single clock, rising edge.
- rst, input, 1, asynchronous reset, active-high.
- flush, input, 1, synchronous clear of the current block; returns the FSM to LOAD.
- in_valid, input, 1, in_data is valid.
- in_ready, output, 1, block accepts a byte this cycle.
- in_data, input, 8, state byte, column-major order (byte i = row i%4, column i/4).
- out_valid, output, 1, out_data is valid.
- out_ready, input, 1, downstream accepts the byte this cycle.
- out_data, output, 8, substituted (and shifted) byte, column-major.
- out_last, output, 1, high with the 16th output byte.
- busy, output, 1, high whenever the FSM is not in LOAD with cnt = 0.

Behaviour:
- Reset (async, rst = 1): FSM = LOAD, cnt = 0, buffer contents don't-care, in_ready = 1, out_valid = 0, out_last = 0, busy = 0, out_data = 0.
- State: 16x8 buffer buf[0..15], 4-bit counter cnt, 1-bit FSM {LOAD, DRAIN}.
- LOAD:
  - in_ready = 1, out_valid = 0.
  - On in_valid & in_ready: buf[cnt] <= SBOX(in_data); cnt <= cnt + 1.
  - On the accept with cnt = 15: cnt wraps to 0 and FSM <= DRAIN.
- DRAIN:
  - in_ready = 0, out_valid = 1.
  - out_data is combinational from buf (registered buffer, muxed output):
    - SHIFT_ROWS = 1: out_data = buf[r + 4*((c + r) mod 4)], with r = cnt%4, c = cnt/4.
    - SHIFT_ROWS = 0: out_data = buf[cnt].
  - out_last = (cnt = 15).
  - On out_ready: cnt <= cnt + 1. On the transfer with cnt = 15: cnt <= 0 and FSM <= LOAD.
- Handshake rules:
  - A transfer occurs only when valid & ready are both high in the same cycle.
  - out_data and out_last stay stable while out_valid = 1 and out_ready = 0.
  - out_valid never drops without a transfer, except on flush or rst.
- Latency and throughput:
  - The first output byte is valid in the cycle after the 16th input byte is accepted.
  - No overlap between blocks: 32 cycles minimum per block with no stalls.
  - The first input byte of the next block is accepted in the cycle after the out_last transfer.
- Flush:
  - Has priority over every other event in the same cycle, including a simultaneous input or output transfer. That transfer is discarded.
  - Sets FSM = LOAD and cnt = 0. The buffer is not cleared.
- Reset mid-block (in either state): partial data is lost, outputs return to reset values immediately, and no out_valid glitch occurs after deassertion.
- in_valid during DRAIN is ignored (in_ready = 0). out_ready during LOAD is ignored.
- All index arithmetic is 2-bit modulo 4; no widening.

Decomposition:
- Package aes_pkg holds:
  - AES_BLOCK_BYTES = 16.
  - The fsm_t enum {LOAD, DRAIN}.
  - Function shift_rows_idx(cnt) returning the 4-bit buffer index.
- Sub-module: one instance of AES_SBox_LUT (.in = in_data, .out = substituted byte). No other sub-modules.

Test Plan:
- FIPS-197 Appendix B round 1, SHIFT_ROWS = 1:
  - Feed 19 3d e3 be a0 f4 e2 2b 9a c6 8d 2a e9 f8 48 08.
  - Required output: d4 bf 5d 30 e0 b4 52 ae b8 41 11 f1 1e 27 98 e5, with out_last only on e5.
- Same input, SHIFT_ROWS = 0 -> d4 27 11 ae e0 bf 98 f1 b8 b4 5d e5 1e 41 52 30.
- All 16 input bytes = 0x00, then all 16 = 0x53 back to back -> 16 x 0x63, then 16 x 0xed.
  - Check the next block's first byte is accepted the cycle after the out_last transfer.
- Random out_ready stalls on vector 1:
  - Output sequence is unchanged.
  - out_data and out_last are held stable across every stall.
  - in_ready stays 0 throughout DRAIN.
- Flush after 7 input bytes, then a full vector 1:
  - Correct vector 1 output, with no leakage of the partial data.
  - Flush asserted together with an output transfer at cnt = 5 -> out_valid = 0 in the next cycle, FSM back in LOAD.
- Assert rst asynchronously mid-DRAIN (between clock edges):
  - out_valid, out_last and busy go to 0 immediately.
  - in_ready goes to 1.
  - After release, vector 1 processes correctly.
